// File: rtl/spi_fb_pkg.sv
// Shared constants for the SPI frame-buffer loader: command codes, header field
// positions and the decoder state encoding.
package spi_fb_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP  = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;

    localparam int HDR_CMD_MSB = 31;
    localparam int HDR_CMD_LSB = 24;
    localparam int HDR_ARG_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_SWAP    = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_DISCARD = 3'd4
    } fb_state_e;

    function automatic logic [7:0] hdr_cmd(input logic [31:0] w);
        return w[HDR_CMD_MSB:HDR_CMD_LSB];
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write FIFO with registered storage; the head entry is
// presented directly so a write is visible the cycle after it is pushed.
module fb_wr_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop && (count_r != {(PTR_W + 1){1'b0}});
        push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
    end

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(PTR_W + 1){1'b0}});

endmodule

// File: rtl/spi_fb_loader.sv
// Decodes SPI header/payload words into buffered frame-buffer writes.
// Optional checksum of WRITE payloads is enabled with `define SPI_FB_CSUM_EN.
module spi_fb_loader
    import spi_fb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       word_in,
    input  logic              word_first,
    input  logic              word_done,
    input  logic              spi_idle,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wdata,
    input  logic              fb_ready,
    output logic              swap_req,
    output logic              busy,
    output logic              err_ovf,
    output logic [31:0]       csum
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    fb_state_e          state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic               err_ovf_r;
    logic               swap_req_r;

    logic               hdr_s;
    logic               data_s;
    logic [7:0]         cmd_s;
    logic [ADDR_W-1:0]  arg_addr_s;
    logic               pop_s;
    logic               can_push_s;
    logic               push_s;
    logic [ADDR_W+31:0] push_data_s;
    logic [ADDR_W+31:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    assign hdr_s      = word_done && word_first;
    assign data_s     = word_done && !word_first;
    assign cmd_s      = hdr_cmd(word_in);
    assign arg_addr_s = word_in[HDR_ARG_LSB +: ADDR_W];
    assign pop_s      = fb_we && fb_ready;
    assign can_push_s = !fifo_full_s || pop_s;

    // Push selection: a header never carries data, so it suppresses any push.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = {addr_r, word_in};
        if (hdr_s) begin
            push_s = 1'b0;
        end else if ((state_r == ST_WRITE) && data_s && can_push_s) begin
            push_s      = 1'b1;
            push_data_s = {addr_r, word_in};
        end else if ((state_r == ST_CLEAR) && can_push_s) begin
            push_s      = 1'b1;
            push_data_s = {addr_r, 32'h0000_0000};
        end else begin
            push_s = 1'b0;
        end
    end

    fb_wr_fifo #(
        .WIDTH (ADDR_W + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Command decoder FSM with address counter, overflow flag and swap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            err_ovf_r  <= 1'b0;
            swap_req_r <= 1'b0;
        end else begin
            swap_req_r <= 1'b0;
            if (hdr_s) begin
                case (cmd_s)
                    CMD_WRITE: begin
                        addr_r  <= arg_addr_s;
                        state_r <= ST_WRITE;
                    end
                    CMD_SWAP:  state_r <= ST_SWAP;
                    CMD_CLEAR: begin
                        addr_r  <= {ADDR_W{1'b0}};
                        state_r <= ST_CLEAR;
                    end
                    default:   state_r <= ST_DISCARD;
                endcase
            end else begin
                case (state_r)
                    ST_WRITE: begin
                        // Dropped words still advance the address.
                        if (data_s) begin
                            addr_r <= addr_r + ADDR_ONE;
                            if (!can_push_s) begin
                                err_ovf_r <= 1'b1;
                            end
                        end
                        if (spi_idle) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_CLEAR: begin
                        if (can_push_s) begin
                            addr_r <= addr_r + ADDR_ONE;
                            if (addr_r == ADDR_MAX) begin
                                state_r <= ST_IDLE;
                            end
                        end
                    end
                    ST_SWAP: begin
                        if (fifo_empty_s) begin
                            swap_req_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (spi_idle) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_FB_CSUM_EN
    logic [31:0] csum_run_r;
    logic [31:0] csum_r;
    logic [31:0] csum_next_s;
    logic        write_exit_s;

    // Running XOR includes words dropped on overflow.
    always_comb begin
        if ((state_r == ST_WRITE) && data_s) begin
            csum_next_s = csum_run_r ^ word_in;
        end else begin
            csum_next_s = csum_run_r;
        end
        write_exit_s = (state_r == ST_WRITE) && (hdr_s || spi_idle);
    end

    // Checksum accumulate, restart on a WRITE header, latch on leaving WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_run_r <= 32'h0000_0000;
            csum_r     <= 32'h0000_0000;
        end else begin
            if (hdr_s && (cmd_s == CMD_WRITE)) begin
                csum_run_r <= 32'h0000_0000;
            end else begin
                csum_run_r <= csum_next_s;
            end
            if (write_exit_s) begin
                csum_r <= csum_next_s;
            end
        end
    end

    assign csum = csum_r;
`else
    assign csum = 32'h0000_0000;
`endif

    assign fb_we    = !fifo_empty_s;
    assign fb_addr  = head_s[ADDR_W+31:32];
    assign fb_wdata = head_s[31:0];
    assign swap_req = swap_req_r;
    assign err_ovf  = err_ovf_r;
    assign busy     = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_spi_fb_loader.sv
// Directed self-checking bench for spi_fb_loader (default ADDR_W=12, FIFO_DEPTH=4).
module tb_spi_fb_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word_in;
    logic        word_first;
    logic        word_done;
    logic        spi_idle;
    logic        fb_we;
    logic [11:0] fb_addr;
    logic [31:0] fb_wdata;
    logic        fb_ready;
    logic        swap_req;
    logic        busy;
    logic        err_ovf;
    logic [31:0] csum;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_cnt      = 0;
    int swap_cnt     = 0;
    int swap_cyc     = 0;
    int last_wr_cyc  = 0;
    logic [43:0] wq[$];

    spi_fb_loader dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_first (word_first),
        .word_done  (word_done),
        .spi_idle   (spi_idle),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_ready   (fb_ready),
        .swap_req   (swap_req),
        .busy       (busy),
        .err_ovf    (err_ovf),
        .csum       (csum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record accepted writes and swap pulses mid-cycle.
    always @(negedge clk) begin
        if (!reset && fb_we && fb_ready) begin
            wq.push_back({fb_addr, fb_wdata});
            last_wr_cyc = cyc_cnt;
        end
        if (!reset && swap_req) begin
            swap_cnt++;
            swap_cyc = cyc_cnt;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [31:0] w, input logic first);
        word_in    = w;
        word_first = first;
        word_done  = 1'b1;
        tick();
        word_done  = 1'b0;
        word_first = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        spi_idle = 1'b0;
        ticks(2);
        reset    = 1'b0;
        wq.delete();
        swap_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        reset      = 1'b1;
        word_in    = 32'h0;
        word_first = 1'b0;
        word_done  = 1'b0;
        spi_idle   = 1'b1;
        fb_ready   = 1'b1;
        tick();

        // Test 1: basic write burst and first-write latency
        do_reset();
        check_eq("rst_we", {63'h0, fb_we}, 64'h0);
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_ovf", {63'h0, err_ovf}, 64'h0);
        check_eq("rst_swap", {63'h0, swap_req}, 64'h0);
        check_eq("rst_csum", {32'h0, csum}, 64'h0);
        send(32'h0100_0010, 1'b1);
        word_in = 32'hA5A5_0001; word_first = 1'b0; word_done = 1'b1;
        check_eq("t1_we_same_cycle", {63'h0, fb_we}, 64'h0);
        tick();
        word_done = 1'b0;
        check_eq("t1_we_next_cycle", {63'h0, fb_we}, 64'h1);
        send(32'hA5A5_0002, 1'b0);
        send(32'hA5A5_0003, 1'b0);
        spi_idle = 1'b1;
        ticks(4);
        check_eq("t1_count", 64'(wq.size()), 64'd3);
        if (wq.size() == 3) begin
            check_eq("t1_w0", {20'h0, wq[0]}, {20'h0, 12'h010, 32'hA5A5_0001});
            check_eq("t1_w1", {20'h0, wq[1]}, {20'h0, 12'h011, 32'hA5A5_0002});
            check_eq("t1_w2", {20'h0, wq[2]}, {20'h0, 12'h012, 32'hA5A5_0003});
        end
        check_eq("t1_busy_done", {63'h0, busy}, 64'h0);

        // Test 2: address wrap
        do_reset();
        send(32'h0100_0FFF, 1'b1);
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        spi_idle = 1'b1;
        ticks(4);
        check_eq("t2_count", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            check_eq("t2_w0", {20'h0, wq[0]}, {20'h0, 12'hFFF, 32'h1111_1111});
            check_eq("t2_wrap", {20'h0, wq[1]}, {20'h0, 12'h000, 32'h2222_2222});
        end

        // Test 3: overflow with stalled RAM port
        do_reset();
        fb_ready = 1'b0;
        send(32'h0100_0020, 1'b1);
        for (int i = 0; i < 6; i++) send(32'hC000_0000 + 32'(i), 1'b0);
        spi_idle = 1'b1;
        ticks(2);
        check_eq("t3_ovf", {63'h0, err_ovf}, 64'h1);
        check_eq("t3_busy", {63'h0, busy}, 64'h1);
        check_eq("t3_stalled", 64'(wq.size()), 64'd0);
        fb_ready = 1'b1;
        ticks(6);
        check_eq("t3_count", 64'(wq.size()), 64'd4);
        if (wq.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check_eq("t3_drain", {20'h0, wq[i]}, {20'h0, 12'h020 + 12'(i), 32'hC000_0000 + 32'(i)});
        end
        check_eq("t3_ovf_sticky", {63'h0, err_ovf}, 64'h1);

        // Test 4: swap waits for pending writes
        do_reset();
        fb_ready = 1'b0;
        send(32'h0100_0100, 1'b1);
        send(32'h0000_00A1, 1'b0);
        send(32'h0000_00A2, 1'b0);
        send(32'h0000_00A3, 1'b0);
        send(32'h0200_0000, 1'b1);
        ticks(4);
        check_eq("t4_no_early_swap", 64'(swap_cnt), 64'd0);
        check_eq("t4_busy", {63'h0, busy}, 64'h1);
        fb_ready = 1'b1;
        ticks(10);
        check_eq("t4_writes", 64'(wq.size()), 64'd3);
        check_eq("t4_swap_once", 64'(swap_cnt), 64'd1);
        check_eq("t4_swap_after", 64'(swap_cyc - last_wr_cyc), 64'd2);

        // Test 5: clear aborted by a write header, then reset mid-clear
        do_reset();
        send(32'h0300_0000, 1'b1);
        ticks(5);
        send(32'h0100_0200, 1'b1);
        send(32'hDEAD_BEEF, 1'b0);
        spi_idle = 1'b1;
        ticks(4);
        check_eq("t5_has_entries", {63'h0, (wq.size() >= 2)}, 64'h1);
        if (wq.size() >= 2) begin
            ok = 1'b1;
            for (int i = 0; i < wq.size() - 1; i++)
                if (wq[i] !== {12'(i), 32'h0}) ok = 1'b0;
            check_eq("t5_clear_seq", {63'h0, ok}, 64'h1);
            check_eq("t5_write_after", {20'h0, wq[wq.size() - 1]}, {20'h0, 12'h200, 32'hDEAD_BEEF});
        end
        check_eq("t5_idle", {63'h0, busy}, 64'h0);
        spi_idle = 1'b0;
        send(32'h0300_0000, 1'b1);
        ticks(3);
        check_eq("t5_clearing", {63'h0, fb_we}, 64'h1);
        reset = 1'b1;
        tick();
        check_eq("t5_rst_we", {63'h0, fb_we}, 64'h0);
        reset = 1'b0;

        // Unknown command discards payload
        do_reset();
        send(32'h7F00_0000, 1'b1);
        send(32'h5555_5555, 1'b0);
        ticks(3);
        check_eq("disc_no_write", 64'(wq.size()), 64'd0);
        spi_idle = 1'b1;
        tick();
        check_eq("disc_idle", {63'h0, busy}, 64'h0);

        // Test 6: checksum
        do_reset();
        send(32'h0100_0300, 1'b1);
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0002, 1'b0);
        send(32'h0000_0004, 1'b0);
        spi_idle = 1'b1;
        ticks(2);
`ifdef SPI_FB_CSUM_EN
        check_eq("t6_csum", {32'h0, csum}, 64'h7);
`else
        check_eq("t6_csum_off", {32'h0, csum}, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
